wb_arch_state: RTL
==================

Name: wb_arch_state

Overview:
Writeback-end consumer of the MEM/WB pipeline register; it holds the architectural state that the WB stage commits.
- Contains the 32-entry GPR file with two read ports and same-cycle WB→ID bypass.
- Contains the HI/LO pair and the LL bit.
- Contains a retired-instruction tracker (PC trace plus 64-bit retire counter) for debug/perf.
- Sits after mem_wb; the read ports feed the ID stage; HI/LO/LLbit feed EX/MEM.

Parameters:
DATA_W, 32, width of GPR/HI/LO/PC
ADDR_W, 5, GPR address width
REG_NUM, 32, number of GPRs (2**ADDR_W)
CNT_W, 64, retire counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high; clock clk
wb_wd  in  ADDR_W  GPR write address from MEM/WB
wb_wreg  in  1  GPR write enable
wb_wdata  in  DATA_W  GPR write data
wb_hi  in  DATA_W  HI write data
wb_lo  in  DATA_W  LO write data
wb_whilo  in  1  HI/LO write enable
wb_LLbit_we  in  1  LL bit write enable
wb_LLbit_value  in  1  LL bit write value
flush  in  1  exception/ERET flush pulse from ctrl
current_pc_i  in  DATA_W  PC of instruction in WB; 0 = bubble
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data (combinational)
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data (combinational)
hi_o  out  DATA_W  architectural HI
lo_o  out  DATA_W  architectural LO
LLbit_o  out  1  architectural LL bit
retire_valid  out  1  one-cycle pulse: an instruction retired last cycle
retire_pc  out  DATA_W  PC of that instruction
retire_count  out  CNT_W  total retired instructions

Behaviour:
Reset (rst=1 at edge):
- All GPRs, hi_o, lo_o, LLbit_o, retire_valid, retire_pc and retire_count are cleared to 0.
- A reset asserted mid-stream discards that cycle's writes.
- While rst=1, rdata1/rdata2 = 0 combinationally.

GPR write:
- At the edge, if wb_wreg=1 and wb_wd≠0, then gpr[wb_wd] <= wb_wdata.
- Writes to $0 are ignored; gpr[0] is always 0.

GPR read (per port, priority order):
1. rst=1 → 0
2. re=0 → 0
3. raddr=0 → 0
4. wb_wreg=1 and raddr=wb_wd → wb_wdata (bypass; the new value is visible in the same cycle)
5. otherwise → gpr[raddr]
- Both ports are independent; the same address on both ports is legal.

HI/LO:
- At the edge, if wb_whilo=1, hi<=wb_hi and lo<=wb_lo; both are always written together.
- Outputs are registered with no bypass; EX forwards from the MEM/WB pipeline itself.

LL bit:
- At the edge: if flush=1, LLbit<=0 (flush has priority over we); else if wb_LLbit_we=1, LLbit<=wb_LLbit_value; else hold.
- LLbit_o is the registered value.

Retire tracking:
- An instruction retires in a cycle iff current_pc_i≠0.
- Bubbles, stalls and flushes arrive as PC 0 from MEM/WB and are not counted.
- At that edge: retire_valid<=1, retire_pc<=current_pc_i, retire_count<=retire_count+1.
- Otherwise retire_valid<=0 and retire_pc holds.
- Latency: 1 cycle.
- flush does not suppress retirement of the instruction currently in WB; it only kills younger stages.
- The counter wraps modulo 2**CNT_W (all-ones + 1 → 0) with no saturation.

Simultaneous events:
- A GPR write, HI/LO write, LL write and retire in the same cycle are all performed.
- flush together with wb_LLbit_we=1 and value 1 → LLbit = 0.

Decomposition:
- Shared defines.v (existing) supplies RstEnable, WriteEnable/WriteDisable, ReadEnable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus and RegNum; no new constants are needed.
- Sub-module gpr_file holds the register array, the write port and both bypassing read ports.
- HI/LO, LL bit and retire logic stay in the top module.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then re1=1, raddr1=5 → rdata1=0; hi_o=lo_o=0; retire_count=0.
- Write/bypass: wb_wreg=1, wb_wd=3, wb_wdata=0xDEADBEEF, same cycle re1=1, raddr1=3 → rdata1=0xDEADBEEF that cycle; next cycle with wb_wreg=0 still 0xDEADBEEF.
- $0 protection: wb_wreg=1, wb_wd=0, wb_wdata=0x1234 → raddr2=0 reads 0 both in the write cycle and afterwards.
- HI/LO and LL flush: wb_whilo=1, hi=0x1, lo=0x2 → next cycle hi_o=1, lo_o=2. Then wb_LLbit_we=1, value=1 → LLbit_o=1. Then flush=1 together with we=1, value=1 → LLbit_o=0.
- Retire: PCs 0xBFC00000, 0, 0xBFC00004 on three cycles → retire_valid pulses on cycles 2 and 4, retire_pc=0xBFC00004 finally, retire_count=2.
- Wrap and reset mid-op: force retire_count to all-ones, retire one → count 0. Then assert rst during a write to r7 → r7 reads 0 afterwards.

Source files
------------

// File: rtl/wb_arch_state_pkg.sv
// rtl/wb_arch_state_pkg.sv - shared widths and enable levels for the WB architectural state
package wb_arch_state_pkg;

   // Default geometry of the architectural state
   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int REG_NUM_DEF = 32;
   localparam int CNT_W_DEF   = 64;

   // Active levels of the pipeline control signals
   localparam logic RST_ENABLE   = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/wb_arch_state_gpr_file.sv
// rtl/wb_arch_state_gpr_file.sv - 32-entry GPR file, one write port, two bypassing read ports
module wb_arch_state_gpr_file
   import wb_arch_state_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int REG_NUM = REG_NUM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re1,
   input  logic [ADDR_W-1:0] i_raddr1,
   output logic [DATA_W-1:0] o_rdata1,
   input  logic              i_re2,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_regs [REG_NUM];

   // Write port: $0 is never written so it stays zero after reset
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we == WRITE_ENABLE && i_waddr != '0) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Read port 1: reset, disable and $0 force zero; a same-cycle WB write is forwarded
   always_comb begin
      o_rdata1 = '0;
      if (rst != RST_ENABLE && i_re1 == READ_ENABLE && i_raddr1 != '0) begin
         if (i_we == WRITE_ENABLE && i_raddr1 == i_waddr) begin
            o_rdata1 = i_wdata;
         end else begin
            o_rdata1 = r_regs[i_raddr1];
         end
      end
   end

   // Read port 2: same priority as port 1, fully independent
   always_comb begin
      o_rdata2 = '0;
      if (rst != RST_ENABLE && i_re2 == READ_ENABLE && i_raddr2 != '0) begin
         if (i_we == WRITE_ENABLE && i_raddr2 == i_waddr) begin
            o_rdata2 = i_wdata;
         end else begin
            o_rdata2 = r_regs[i_raddr2];
         end
      end
   end

endmodule

// File: rtl/wb_arch_state.sv
// rtl/wb_arch_state.sv - WB-stage architectural state: GPRs, HI/LO, LL bit, retire tracker
module wb_arch_state
   import wb_arch_state_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic              wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              wb_whilo,
   input  logic              wb_LLbit_we,
   input  logic              wb_LLbit_value,
   input  logic              flush,
   input  logic [DATA_W-1:0] current_pc_i,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              LLbit_o,
   output logic              retire_valid,
   output logic [DATA_W-1:0] retire_pc,
   output logic [CNT_W-1:0]  retire_count
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic              r_llbit;
   logic              r_retire_valid;
   logic [DATA_W-1:0] r_retire_pc;
   logic [CNT_W-1:0]  r_retire_count;
   logic              w_retiring;

   wb_arch_state_gpr_file #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .REG_NUM (REG_NUM)
   ) u_gpr_file (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_wreg),
      .i_waddr  (wb_wd),
      .i_wdata  (wb_wdata),
      .i_re1    (re1),
      .i_raddr1 (raddr1),
      .o_rdata1 (rdata1),
      .i_re2    (re2),
      .i_raddr2 (raddr2),
      .o_rdata2 (rdata2)
   );

   // HI and LO are always committed as a pair; no bypass, EX forwards from MEM/WB itself
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (wb_whilo == WRITE_ENABLE) begin
         r_hi <= wb_hi;
         r_lo <= wb_lo;
      end
   end

   // LL bit: a flush breaks any pending LL/SC pair, overriding a same-cycle LL write
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_llbit <= 1'b0;
      end else if (flush) begin
         r_llbit <= 1'b0;
      end else if (wb_LLbit_we == WRITE_ENABLE) begin
         r_llbit <= wb_LLbit_value;
      end
   end

   // A nonzero PC in WB is a real instruction; flush only kills younger stages
   assign w_retiring = (current_pc_i != '0);

   // Retire tracker: one-cycle pulse, last retired PC, free-running wrapping count
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_retire_valid <= 1'b0;
         r_retire_pc    <= '0;
         r_retire_count <= '0;
      end else if (w_retiring) begin
         r_retire_valid <= 1'b1;
         r_retire_pc    <= current_pc_i;
         r_retire_count <= r_retire_count + CNT_W'(1);
      end else begin
         r_retire_valid <= 1'b0;
      end
   end

   assign hi_o         = r_hi;
   assign lo_o         = r_lo;
   assign LLbit_o      = r_llbit;
   assign retire_valid = r_retire_valid;
   assign retire_pc    = r_retire_pc;
   assign retire_count = r_retire_count;

endmodule
